gin_tag_sequencer: RTL and testbench
====================================

// Module: gin_tag_sequencer
// PURPOSE
//  Upstream feeder for the GIN bus hierarchy: accepts a GLB read-data stream
//  and stamps each word with a (row tag, column tag) pair from a configured loop nest.
//  Presents words as a registered valid/ready master stream to the Y-bus, whose X-buses and
//  multicast controllers match these tags against scanned-in PE IDs. One word issued per accepted input.
// PARAMETERS
//  XID_W    `XID_BITS   column-tag width (X-bus tag)
//  YID_W    `YID_BITS   row-tag width (Y-bus tag)
//  REP_W    8           width of repeat counter (whole tag sweep replayed up to 2^REP_W times)
// PORTS
//  clk            in   1           single clock, all logic rising-edge
//  rst            in   1           synchronous, active-high reset
//  start          in   1           pulse: latch cfg_*, begin sequence (ignored unless IDLE)
//  cfg_x_base     in   XID_W       first column tag
//  cfg_x_last     in   XID_W       last column index (count = cfg_x_last+1)
//  cfg_y_base     in   YID_W       first row tag
//  cfg_y_last     in   YID_W       last row index (count = cfg_y_last+1)
//  cfg_rep_last   in   REP_W       last repeat index (count = cfg_rep_last+1)
//  busy           out  1           high from cycle after accepted start until done
//  done           out  1           one-cycle pulse after final output handshake
//  in_valid       in   1           GLB word valid
//  in_data        in   `DATA_BITS  GLB word
//  in_ready       out  1           GLB word accepted when in_valid&&in_ready
//  out_valid      out  1           to Y-bus master_valid
//  out_data       out  `DATA_BITS  to Y-bus master_data
//  out_tag_y      out  YID_W       row tag
//  out_tag_x      out  XID_W       column tag
//  out_ready      in   1           from Y-bus master_ready
// BEHAVIOUR
//  Reset: state=IDLE; busy=0, done=0, in_ready=0, out_valid=0, out_data/out_tag_*=0, counters=0.
//  FSM: IDLE -start-> RUN; RUN -last word accepted from input-> DRAIN; DRAIN -out handshake-> DONE;
//   DONE -> IDLE (done=1 this cycle only). If the last input word is accepted while the output register is empty
//   or draining the same cycle, DRAIN is still entered and exits on that word's handshake.
//  Output register (1 entry): in_ready = (state==RUN) && (!out_valid || out_ready).
//   Input accept loads out_data=in_data, out_tag_x=x_base+x_cnt, out_tag_y=y_base+y_cnt, out_valid=1.
//   Handshake without new accept clears out_valid. Latency input->output: 1 cycle. Full throughput 1 word/clk.
//  out_valid stays high and out_data/out_tag_* stay stable until out_ready (no retraction).
//  Counters advance on input accept: x_cnt++; at x_cnt==x_last wrap to 0 and y_cnt++;
//   at y_cnt==y_last also wrap y_cnt to 0 and rep_cnt++; last word = all three at their last values.
//  Tag arithmetic: base+cnt truncated modulo 2^XID_W / 2^YID_W (wrap, no saturation).
//  Total words per sequence = (x_last+1)*(y_last+1)*(rep_last+1). All-zero cfg = exactly 1 word.
//  start while busy: ignored, cfg unchanged. Input valid while IDLE/DRAIN: not accepted (in_ready=0).
//  rst mid-sequence: immediate abort, in-flight output word dropped, done NOT pulsed.
// CONFIGURATION
//  GIN_TAG_PERF_EN defined: extra outputs perf_stall[31:0] (cycles out_valid&&!out_ready)
//   and perf_starve[31:0] (cycles RUN&&!in_valid&&!out_valid); both clear on rst and on accepted start,
//   saturate at 2^32-1. Not defined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  gin_pkg: typedef enum logic[1:0] {IDLE,RUN,DRAIN,DONE} gin_seq_state_e;
//   typedef logic[`XID_BITS-1:0] xid_t; typedef logic[`YID_BITS-1:0] yid_t.
//  Sub-module gin_out_reg: single-entry valid/ready register carrying {tag_y,tag_x,data};
//   top holds FSM, cfg latches and loop counters.
// TESTING
//  1 rst, start x_base=2 x_last=3 y_base=0 y_last=1 rep_last=0, out_ready=1, in_valid=1 data=i
//    -> 8 words, tags (y,x)=(0,2)(0,3)(0,4)(0,5)(1,2)..(1,5), data 0..7 in order, done 1 cycle after last handshake.
//  2 same cfg, out_ready toggled random 50% -> identical sequence, out_* stable while stalled, no loss/duplication.
//  3 x_base=15,x_last=3 with XID_W=4 -> x tags 15,0,1,2 (modulo wrap).
//  4 all cfg=0 -> exactly one word tag (y_base,x_base), busy 1->0, single done pulse.
//  5 rep_last=2, x_last=1,y_last=0 -> 6 words, x tags 0,1,0,1,0,1; second start mid-run ignored.
//  6 rst asserted after 3rd word -> next cycle out_valid=0,busy=0,done=0; new start restarts at x_cnt=0.

Source files
------------

// File: rtl/gin_pkg.sv
// Shared types for the GIN tag sequencer.
// Tag and data widths come from the XID_BITS / YID_BITS / DATA_BITS macros;
// defaults are provided here when the build does not set them.
`ifndef XID_BITS
`define XID_BITS 4
`endif
`ifndef YID_BITS
`define YID_BITS 4
`endif
`ifndef DATA_BITS
`define DATA_BITS 16
`endif

package gin_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} gin_seq_state_e;
    typedef logic [`XID_BITS-1:0] xid_t;
    typedef logic [`YID_BITS-1:0] yid_t;
endpackage

// File: rtl/gin_out_reg.sv
// Single-entry valid/ready output register carrying {tag_y, tag_x, data}.
// A load always wins; otherwise a handshake empties the entry. Contents
// are held untouched while valid is high and ready is low.
module gin_out_reg #(
    parameter int W = 24
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_payload,
    input  logic         ready,
    output logic         valid,
    output logic [W-1:0] payload
);

    // Entry state: load new word, or drop the current one once taken downstream.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid   <= 1'b0;
            payload <= '0;
        end else if (load) begin
            valid   <= 1'b1;
            payload <= load_payload;
        end else if (ready) begin
            valid   <= 1'b0;
        end
    end

endmodule

// File: rtl/gin_tag_sequencer.sv
// GIN tag sequencer: stamps each accepted GLB word with (row, column) tags
// from a configured x/y/repeat loop nest and presents it on a registered
// valid/ready stream to the Y-bus.
// Optional build macro GIN_TAG_PERF_EN adds perf_stall / perf_starve counters.
module gin_tag_sequencer
    import gin_pkg::*;
#(
    parameter int XID_W  = `XID_BITS,
    parameter int YID_W  = `YID_BITS,
    parameter int REP_W  = 8,
    parameter int DATA_W = `DATA_BITS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [XID_W-1:0]  cfg_x_base,
    input  logic [XID_W-1:0]  cfg_x_last,
    input  logic [YID_W-1:0]  cfg_y_base,
    input  logic [YID_W-1:0]  cfg_y_last,
    input  logic [REP_W-1:0]  cfg_rep_last,
    output logic              busy,
    output logic              done,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [YID_W-1:0]  out_tag_y,
    output logic [XID_W-1:0]  out_tag_x,
    input  logic              out_ready
`ifdef GIN_TAG_PERF_EN
    ,
    output logic [31:0]       perf_stall,
    output logic [31:0]       perf_starve
`endif
);

    localparam int PW = YID_W + XID_W + DATA_W;

    gin_seq_state_e   state_q, state_d;
    logic [XID_W-1:0] x_base_q, x_last_q, x_cnt_q;
    logic [YID_W-1:0] y_base_q, y_last_q, y_cnt_q;
    logic [REP_W-1:0] rep_last_q, rep_cnt_q;
    logic             start_ok, accept, x_wrap, y_wrap, last_word;
    logic [PW-1:0]    load_payload, payload;

    assign start_ok  = start && (state_q == IDLE);
    assign in_ready  = (state_q == RUN) && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign x_wrap    = (x_cnt_q == x_last_q);
    assign y_wrap    = (y_cnt_q == y_last_q);
    assign last_word = x_wrap && y_wrap && (rep_cnt_q == rep_last_q);

    // Tags wrap modulo the tag width: base + count is simply truncated.
    assign load_payload = {y_base_q + y_cnt_q, x_base_q + x_cnt_q, in_data};
    assign {out_tag_y, out_tag_x, out_data} = payload;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Sequence control: next state plus busy/done decode.
    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) state_d = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (accept && last_word) state_d = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (out_valid && out_ready) state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Configuration is captured only by a start seen in IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_base_q   <= '0;
            x_last_q   <= '0;
            y_base_q   <= '0;
            y_last_q   <= '0;
            rep_last_q <= '0;
        end else if (start_ok) begin
            x_base_q   <= cfg_x_base;
            x_last_q   <= cfg_x_last;
            y_base_q   <= cfg_y_base;
            y_last_q   <= cfg_y_last;
            rep_last_q <= cfg_rep_last;
        end
    end

    // Loop nest: x innermost, then y, then repeat; advances on each accepted word.
    always_ff @(posedge clk) begin
        if (rst || start_ok) begin
            x_cnt_q   <= '0;
            y_cnt_q   <= '0;
            rep_cnt_q <= '0;
        end else if (accept) begin
            if (!x_wrap) begin
                x_cnt_q <= x_cnt_q + 1'b1;
            end else begin
                x_cnt_q <= '0;
                if (!y_wrap) begin
                    y_cnt_q <= y_cnt_q + 1'b1;
                end else begin
                    y_cnt_q   <= '0;
                    rep_cnt_q <= rep_cnt_q + 1'b1;
                end
            end
        end
    end

    gin_out_reg #(.W(PW)) u_out_reg (
        .clk          (clk),
        .rst          (rst),
        .load         (accept),
        .load_payload (load_payload),
        .ready        (out_ready),
        .valid        (out_valid),
        .payload      (payload)
    );

`ifdef GIN_TAG_PERF_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Stall / starve counters, cleared by reset and by each accepted start.
    always_ff @(posedge clk) begin
        if (rst || start_ok) begin
            perf_stall  <= '0;
            perf_starve <= '0;
        end else begin
            if (out_valid && !out_ready)
                perf_stall <= sat_inc(perf_stall);
            if ((state_q == RUN) && !in_valid && !out_valid)
                perf_starve <= sat_inc(perf_starve);
        end
    end
`endif

endmodule

// File: tb/tb_gin_tag_sequencer.sv
// Directed testbench for gin_tag_sequencer (XID/YID width 4, data width 16).
module tb_gin_tag_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  cfg_x_base = '0, cfg_x_last = '0, cfg_y_base = '0, cfg_y_last = '0;
    logic [7:0]  cfg_rep_last = '0;
    logic        busy, done;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = '0;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] out_data;
    logic [3:0]  out_tag_y, out_tag_x;
    logic        out_ready = 1'b1;
`ifdef GIN_TAG_PERF_EN
    logic [31:0] perf_stall, perf_starve;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    gin_tag_sequencer #(.XID_W(4), .YID_W(4), .REP_W(8), .DATA_W(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .cfg_x_base   (cfg_x_base),
        .cfg_x_last   (cfg_x_last),
        .cfg_y_base   (cfg_y_base),
        .cfg_y_last   (cfg_y_last),
        .cfg_rep_last (cfg_rep_last),
        .busy         (busy),
        .done         (done),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_tag_y    (out_tag_y),
        .out_tag_x    (out_tag_x),
        .out_ready    (out_ready)
`ifdef GIN_TAG_PERF_EN
        ,
        .perf_stall   (perf_stall),
        .perf_starve  (perf_starve)
`endif
    );

    // Runs one sequence; words are checked against the loop-nest model as they
    // are handed off. restart_at / abort_at (>=0) inject a start or a reset.
    task automatic run_seq(input logic [3:0] xb, input logic [3:0] xl,
                           input logic [3:0] yb, input logic [3:0] yl,
                           input logic [7:0] rl, input bit rnd,
                           input int restart_at, input int abort_at,
                           input string nm);
        int total, acc, got, cyc, xi, yi;
        bit hold_v, restarted;
        logic [15:0] hd;
        logic [3:0] hx, hy, ex, ey;
        total = (int'(xl) + 1) * (int'(yl) + 1) * (int'(rl) + 1);
        acc = 0; got = 0; cyc = 0; hold_v = 0; restarted = 0;
        hd = '0; hx = '0; hy = '0;
        @(negedge clk);
        cfg_x_base = xb; cfg_x_last = xl; cfg_y_base = yb; cfg_y_last = yl;
        cfg_rep_last = rl; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cfg_x_base = 4'hA; cfg_x_last = 4'h6; cfg_y_base = 4'h9; cfg_y_last = 4'h5;
        cfg_rep_last = 8'h3;
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL %s busy_after_start: got %b want 1", nm, busy);
        end
        in_valid = 1'b1;
        while (1) begin
            start = 1'b0;
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            in_data = 16'(acc);
            if (restart_at >= 0 && !restarted && got == restart_at) begin
                start = 1'b1; cfg_x_last = 4'd7; restarted = 1;
            end
            #1;
            if (hold_v) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== hd || out_tag_x !== hx || out_tag_y !== hy) begin
                    errors++;
                    $display("FAIL %s stall_hold: got v=%b d=%0d x=%0d y=%0d want v=1 d=%0d x=%0d y=%0d",
                             nm, out_valid, out_data, out_tag_x, out_tag_y, hd, hx, hy);
                end
            end
            if (out_valid && out_ready) begin
                xi = got % (int'(xl) + 1);
                yi = (got / (int'(xl) + 1)) % (int'(yl) + 1);
                ex = xb + 4'(xi);
                ey = yb + 4'(yi);
                checks++;
                if (out_data !== 16'(got) || out_tag_x !== ex || out_tag_y !== ey) begin
                    errors++;
                    $display("FAIL %s word%0d: got d=%0d y=%0d x=%0d want d=%0d y=%0d x=%0d",
                             nm, got, out_data, out_tag_y, out_tag_x, got, ey, ex);
                end
                got++;
            end
            hold_v = out_valid && !out_ready;
            hd = out_data; hx = out_tag_x; hy = out_tag_y;
            if (in_valid && in_ready) acc++;
            if (got == total || (abort_at >= 0 && got == abort_at) || cyc >= 2000) break;
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b1; start = 1'b0;
        if (abort_at >= 0 && got == abort_at) begin
            @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
                errors++;
                $display("FAIL %s abort: got v=%b busy=%b done=%b want 0 0 0", nm, out_valid, busy, done);
            end
            rst = 1'b0;
            return;
        end
        checks++;
        if (got != total) begin
            errors++; $display("FAIL %s word_count: got %0d want %0d", nm, got, total);
        end
        if (!rnd) begin
            checks++;
            if (cyc != total) begin
                errors++; $display("FAIL %s throughput_cycles: got %0d want %0d", nm, cyc, total);
            end
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL %s done_pulse: got done=%b busy=%b want 1 0", nm, done, busy);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s after_done: got done=%b busy=%b v=%b want 0 0 0", nm, done, busy, out_valid);
        end
        checks++;
        if (acc != total) begin
            errors++; $display("FAIL %s accepted_count: got %0d want %0d", nm, acc, total);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; in_data = 16'h1234;
        repeat (3) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || in_ready !== 1'b0 ||
            out_data !== 16'h0 || out_tag_x !== 4'h0 || out_tag_y !== 4'h0) begin
            errors++;
            $display("FAIL reset_state: got v=%b busy=%b done=%b rdy=%b d=%0d x=%0d y=%0d want all 0",
                     out_valid, busy, done, in_ready, out_data, out_tag_x, out_tag_y);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL idle_no_accept: got rdy=%b v=%b want 0 0", in_ready, out_valid);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_basic();
        run_seq(4'd2, 4'd3, 4'd0, 4'd1, 8'd0, 1'b0, -1, -1, "basic");
    endtask

    task automatic test_backpressure();
        run_seq(4'd2, 4'd3, 4'd0, 4'd1, 8'd0, 1'b1, -1, -1, "backpressure");
    endtask

    task automatic test_tag_wrap();
        run_seq(4'd15, 4'd3, 4'd5, 4'd0, 8'd0, 1'b0, -1, -1, "tag_wrap");
    endtask

    task automatic test_single_word();
        run_seq(4'd0, 4'd0, 4'd0, 4'd0, 8'd0, 1'b0, -1, -1, "single_word");
    endtask

    task automatic test_repeat_restart();
        run_seq(4'd0, 4'd1, 4'd0, 4'd0, 8'd2, 1'b0, 2, -1, "repeat_restart");
    endtask

    task automatic test_abort();
        run_seq(4'd1, 4'd3, 4'd2, 4'd1, 8'd0, 1'b0, -1, 3, "abort");
        run_seq(4'd1, 4'd3, 4'd2, 4'd1, 8'd0, 1'b0, -1, -1, "after_abort");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_tag_wrap();
        test_single_word();
        test_repeat_restart();
        test_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
